// File: rtl/alu_exec_stage.sv
// 20-bit single-entry ALU execute stage; optional ADC carry chain under ALU_CARRY_CHAIN_EN.
// Latency 1 cycle from accept to out_valid; full throughput with simultaneous consume/accept.
// Backpressure: in_ready = !out_valid || out_ready; result and flags hold while stalled.
module alu_exec_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [19:0]      in_a,
    input  logic [19:0]      in_b,
    input  logic [3:0]       in_shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [19:0]      out_res,
    output logic             out_carry,
    output logic             out_zero,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_ADC   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_NOT   = 3'd4;
    localparam logic [2:0] OP_SHL   = 3'd5;
    localparam logic [2:0] OP_SHR   = 3'd6;
    localparam logic [2:0] OP_PASSB = 3'd7;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [19:0]       r_res;
    logic              r_carry;
    logic              r_zero;
    logic [CNT_W-1:0]  r_count;

    logic              w_accept;
    logic              w_consume;
    logic              w_cin;
    logic [20:0]       w_sum;
    logic [20:0]       w_shl;
    logic [20:0]       w_shr;
    logic [19:0]       w_res;
    logic              w_carry;

    assign out_valid = (r_state == S_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_consume = out_valid && out_ready;

`ifdef ALU_CARRY_CHAIN_EN
    logic r_cflag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cflag <= 1'b0;
        end else if (w_accept && (in_op == OP_ADD || in_op == OP_ADC ||
                                  in_op == OP_SHL || in_op == OP_SHR)) begin
            r_cflag <= w_carry;
        end
    end

    assign w_cin = (in_op == OP_ADC) ? r_cflag : 1'b0;
`else
    assign w_cin = 1'b0;
`endif

    // Widened operands put the carry-out (add), last bit shifted out (shl/shr) in a fixed bit.
    assign w_sum = {1'b0, in_a} + {1'b0, in_b} + {20'd0, w_cin};
    assign w_shl = {1'b0, in_a} << in_shamt;
    assign w_shr = {in_a, 1'b0} >> in_shamt;

    always_comb begin
        w_res   = 20'd0;
        w_carry = 1'b0;
        case (in_op)
            OP_ADD, OP_ADC: begin
                w_res   = w_sum[19:0];
                w_carry = w_sum[20];
            end
            OP_AND:   w_res = in_a & in_b;
            OP_OR:    w_res = in_a | in_b;
            OP_NOT:   w_res = ~in_a;
            OP_SHL: begin
                w_res   = w_shl[19:0];
                w_carry = w_shl[20];
            end
            OP_SHR: begin
                w_res   = w_shr[20:1];
                w_carry = w_shr[0];
            end
            OP_PASSB: w_res = in_b;
            default:  w_res = 20'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
            S_FULL:  if (w_consume && !w_accept) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res   <= 20'd0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_res   <= w_res;
            r_carry <= w_carry;
            r_zero  <= (w_res == 20'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_consume) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign out_res   = r_res;
    assign out_carry = r_carry;
    assign out_zero  = r_zero;
    assign op_count  = r_count;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: ops, flags, backpressure, streaming, async reset.
module tb_alu_exec_stage;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [19:0]      in_a;
    logic [19:0]      in_b;
    logic [3:0]       in_shamt;
    logic             out_valid;
    logic             out_ready;
    logic [19:0]      out_res;
    logic             out_carry;
    logic             out_zero;
    logic [CNT_W-1:0] op_count;

    int n_tests;
    int n_fail;

    alu_exec_stage #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_shamt  (in_shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_carry (out_carry),
        .out_zero  (out_zero),
        .op_count  (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [19:0] a,
                         input logic [19:0] b, input logic [3:0] sh, input logic ordy);
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_shamt  = sh;
        out_ready = ordy;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [19:0] res,
                             input logic c, input logic z, input int cnt);
        check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        check({tag, ".res"},   {12'd0, out_res},   {12'd0, res});
        check({tag, ".carry"}, {31'd0, out_carry}, {31'd0, c});
        check({tag, ".zero"},  {31'd0, out_zero},  {31'd0, z});
        check({tag, ".cnt"},   {16'd0, op_count},  cnt);
    endtask

    initial begin
        logic [19:0] adc_exp;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        drive(1'b0, 3'd0, 20'd0, 20'd0, 4'd0, 1'b1);
        #2;
        check_out("reset", 1'b0, 20'd0, 1'b0, 1'b0, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset.in_ready", {31'd0, in_ready}, 32'd1);

        drive(1'b1, 3'd0, 20'hFFFFF, 20'h00001, 4'd0, 1'b1);
        tick();
        check_out("add_wrap", 1'b1, 20'd0, 1'b1, 1'b1, 0);

`ifdef ALU_CARRY_CHAIN_EN
        adc_exp = 20'd12;
`else
        adc_exp = 20'd11;
`endif
        drive(1'b1, 3'd1, 20'd5, 20'd6, 4'd0, 1'b1);
        tick();
        check_out("adc", 1'b1, adc_exp, 1'b0, 1'b0, 1);

        drive(1'b1, 3'd5, 20'h80001, 20'd0, 4'd1, 1'b1);
        tick();
        check_out("shl1", 1'b1, 20'h00002, 1'b1, 1'b0, 2);

        drive(1'b1, 3'd6, 20'h00003, 20'd0, 4'd1, 1'b1);
        tick();
        check_out("shr1", 1'b1, 20'h00001, 1'b1, 1'b0, 3);

        drive(1'b1, 3'd5, 20'h12345, 20'd0, 4'd0, 1'b1);
        tick();
        check_out("shl0", 1'b1, 20'h12345, 1'b0, 1'b0, 4);

        drive(1'b1, 3'd6, 20'h80000, 20'd0, 4'd15, 1'b1);
        tick();
        check_out("shr15", 1'b1, 20'h00010, 1'b0, 1'b0, 5);

        drive(1'b1, 3'd2, 20'hFF00F, 20'h0F0FF, 4'd0, 1'b1);
        tick();
        check_out("and", 1'b1, 20'h0F00F, 1'b0, 1'b0, 6);

        drive(1'b1, 3'd4, 20'h00000, 20'h12345, 4'd0, 1'b1);
        tick();
        check_out("not", 1'b1, 20'hFFFFF, 1'b0, 1'b0, 7);

        drive(1'b1, 3'd7, 20'hABCDE, 20'h00000, 4'd0, 1'b1);
        tick();
        check_out("passb", 1'b1, 20'h00000, 1'b0, 1'b1, 8);

        drive(1'b1, 3'd3, 20'hF0F0F, 20'h0F0F0, 4'd0, 1'b1);
        tick();
        check_out("or", 1'b1, 20'hFFFFF, 1'b0, 1'b0, 9);

        drive(1'b1, 3'd0, 20'd1, 20'd1, 4'd0, 1'b0);
        #1;
        check("bp.in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp.in_ready_hold", {31'd0, in_ready}, 32'd0);
            check_out("bp.hold", 1'b1, 20'hFFFFF, 1'b0, 1'b0, 9);
        end
        drive(1'b0, 3'd0, 20'd0, 20'd0, 4'd0, 1'b1);
        #1;
        check("bp.release_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        check_out("bp.drain", 1'b0, 20'hFFFFF, 1'b0, 1'b0, 10);

        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 3'd0, 20'(k), 20'd100, 4'd0, 1'b1);
            #1;
            check("stream.in_ready", {31'd0, in_ready}, 32'd1);
            tick();
            check_out("stream", 1'b1, 20'(k + 100), 1'b0, 1'b0, 10 + k);
        end
        drive(1'b0, 3'd0, 20'd0, 20'd0, 4'd0, 1'b1);
        tick();
        check_out("stream.end", 1'b0, 20'd109, 1'b0, 1'b0, 20);

        drive(1'b1, 3'd0, 20'hFFFF0, 20'h00018, 4'd0, 1'b0);
        tick();
        check_out("pre_arst", 1'b1, 20'h00008, 1'b1, 1'b0, 20);
        #2;
        rst = 1'b1;
        #1;
        check_out("arst", 1'b0, 20'd0, 1'b0, 1'b0, 0);
        tick();
        check_out("arst.held", 1'b0, 20'd0, 1'b0, 1'b0, 0);
        rst = 1'b0;
        drive(1'b1, 3'd0, 20'd2, 20'd3, 4'd0, 1'b1);
        tick();
        check_out("post_arst", 1'b1, 20'd5, 1'b0, 1'b0, 0);
        drive(1'b0, 3'd0, 20'd0, 20'd0, 4'd0, 1'b1);
        tick();
        check_out("post_arst.drain", 1'b0, 20'd5, 1'b0, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 Parameter CNT_W, default 16: width of the completed-operation counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  upstream command valid.
REQ-005 in_ready  output  1  stage can accept a command this cycle.
REQ-006 in_op  input  3  opcode: 0 ADD, 1 ADC, 2 AND, 3 OR, 4 NOT, 5 SHL, 6 SHR, 7 PASSB.
REQ-007 in_a  input  20  operand A.
REQ-008 in_b  input  20  operand B.
REQ-009 in_shamt  input  4  shift amount for SHL/SHR.
REQ-010 out_valid  output  1  result register holds an unconsumed result.
REQ-011 out_ready  input  1  downstream accepts the result this cycle.
REQ-012 out_res  output  20  registered result.
REQ-013 out_carry  output  1  registered carry flag of the result.
REQ-014 out_zero  output  1  registered flag, 1 when out_res == 0.
REQ-015 op_count  output  CNT_W  number of results consumed downstream.

Function
REQ-016 The stage SHALL hold two states, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-018 A command SHALL be accepted on a rising edge where in_valid && in_ready; its result SHALL appear on out_res with out_valid=1 on the following cycle (latency 1).
REQ-019 A result SHALL be consumed on a rising edge where out_valid && out_ready.
REQ-020 EMPTY->FULL on accept; FULL->EMPTY on consume without accept; FULL->FULL on simultaneous consume and accept, with the register loaded with the new result (full throughput, no bubble).
REQ-021 While FULL and out_ready=0, out_res, out_carry and out_zero SHALL hold stable, and in_ready SHALL be 0.
REQ-022 ADD: {carry,res} = a + b, computed 21 bits wide; ADC: {carry,res} = a + b + cflag (see REQ-030).
REQ-023 AND: a & b; OR: a | b; NOT: ~a; PASSB: b; for all four, carry = 0.
REQ-024 SHL: a << shamt, logical, zero fill; carry = last bit shifted out (a[20-shamt] for shamt>0, else 0).
REQ-025 SHR: a >> shamt, logical, zero fill; carry = a[shamt-1] for shamt>0, else 0.
REQ-026 out_zero SHALL be computed from the result being loaded, not from the previous result.
REQ-027 op_count SHALL increment by 1 on every consume and wrap from all-ones to 0 without a flag.
REQ-028 in_a, in_b, in_op and in_shamt SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-029 On rst=1, the block SHALL immediately force out_valid=0, out_res=0, out_carry=0, out_zero=0, op_count=0 and the internal carry register=0, independent of clk. A result pending at that moment SHALL be discarded, and no command is accepted while rst=1.

Configuration
REQ-030 With macro ALU_CARRY_CHAIN_EN defined, an internal carry register SHALL load the carry of every accepted ADD, ADC, SHL and SHR, and ADC SHALL use it as carry-in. The register SHALL be unchanged by AND, OR, NOT and PASSB.
REQ-031 Without ALU_CARRY_CHAIN_EN, the carry register SHALL not exist, and ADC SHALL behave exactly as ADD (carry-in 0).

Verification
REQ-032 ADD a=20'hFFFFF, b=20'h00001, out_ready=1 -> next cycle out_res=0, out_carry=1, out_zero=1, out_valid=1.
REQ-033 With macro: ADD 20'hFFFFF+1, then ADC a=5, b=6 -> second result 12, carry 0. Without macro: same sequence -> 11.
REQ-034 SHL a=20'h80001, shamt=1 -> out_res=20'h00002, out_carry=1. SHR a=20'h00003, shamt=1 -> out_res=1, out_carry=1. SHL shamt=0 -> out_res=a, carry 0.
REQ-035 Backpressure: load OR 20'hF0F0F|20'h0F0F0, hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_res=20'hFFFFF stable, op_count=0. Release -> consumed, op_count=1.
REQ-036 Streaming: in_valid=1 and out_ready=1 for 10 back-to-back commands -> 10 results on consecutive cycles, in_ready constantly 1, op_count=10.
REQ-037 Assert rst asynchronously between clock edges while FULL -> out_valid and all outputs go to 0 before the next edge; the first command after deassertion completes normally.
